fmlbrg_cachemem: RTL and testbench

Storage core of the Wishbone-to-FML 8x16 write-back cache bridge. Holds the tag RAM (valid + dirty + tag per line) and the data RAM (16-bit words with byte write enables). Each RAM has one read/write port for the bridge FSM and one read-only port for the Direct Cache Bus. All reads are synchronous and write-first, with one cycle of latency.

---
 rtl/fmlbrg_pkg.sv | 17 +
 rtl/fmlbrg_dpram.sv | 48 ++++
 rtl/fmlbrg_cachemem.sv | 85 ++++++++
 tb/tb_fmlbrg_cachemem.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmlbrg_pkg.sv
// Shared widths and field positions for the Wishbone-to-FML cache bridge.
package fmlbrg_pkg;

  localparam int unsigned FML_DEPTH   = 23;
  localparam int unsigned CACHE_DEPTH = 9;

  localparam int unsigned TAG_DEPTH  = CACHE_DEPTH - 4;
  localparam int unsigned TAG_WIDTH  = FML_DEPTH - CACHE_DEPTH + 2;
  localparam int unsigned DATA_DEPTH = CACHE_DEPTH - 1;

  localparam int unsigned VALID_BIT = TAG_WIDTH - 1;
  localparam int unsigned DIRTY_BIT = TAG_WIDTH - 2;

  localparam int unsigned BYTE_LANES = 2;
  localparam int unsigned BYTE_W     = 8;

endpackage

// File: rtl/fmlbrg_dpram.sv
// 1RW + 1R synchronous RAM with per-lane write enables and registered-address,
// write-first reads. Writes are suppressed while rst_n is low.
module fmlbrg_dpram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned LANE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        a,
  input  logic [LANES-1:0]         we,
  input  logic [LANES*LANE_W-1:0]  di,
  output logic [LANES*LANE_W-1:0]  rdata,
  input  logic [ADDR_W-1:0]        a2,
  output logic [LANES*LANE_W-1:0]  rdata2
);

  localparam int unsigned W     = LANES * LANE_W;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] a_r;
  logic [ADDR_W-1:0] a2_r;

  // Storage array: not reset, byte-lane merged writes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (rst_n && we[i]) begin
        mem[a][i*LANE_W +: LANE_W] <= di[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= '0;
      a2_r <= '0;
    end else begin
      a_r  <= a;
      a2_r <= a2;
    end
  end

  // Reading the array at the registered address gives write-first behaviour.
  assign rdata  = mem[a_r];
  assign rdata2 = mem[a2_r];

endmodule

// File: rtl/fmlbrg_cachemem.sv
// Tag and data storage of the write-back cache bridge. Valid flags are kept in
// resettable flops; tag/dirty bits and data live in non-reset RAMs.
module fmlbrg_cachemem
  import fmlbrg_pkg::*;
#(
  parameter int unsigned tag_depth  = TAG_DEPTH,
  parameter int unsigned tag_width  = TAG_WIDTH,
  parameter int unsigned data_depth = DATA_DEPTH
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,

  input  logic [tag_depth-1:0]   tm_a,
  input  logic                   tm_we,
  input  logic [tag_width-1:0]   tm_di,
  output logic [tag_width-1:0]   tm_do,
  input  logic [tag_depth-1:0]   tm_a2,
  output logic [tag_width-1:0]   tm_do2,

  input  logic [data_depth-1:0]  dm_a,
  input  logic [BYTE_LANES-1:0]  dm_we,
  input  logic [15:0]            dm_di,
  output logic [15:0]            dm_do,
  input  logic [data_depth-1:0]  dm_a2,
  output logic [15:0]            dm_do2
);

  localparam int unsigned LINES  = 2 ** tag_depth;
  localparam int unsigned TRAM_W = tag_width - 1;

  logic [LINES-1:0]     valid;
  logic [tag_depth-1:0] tm_a_r;
  logic [tag_depth-1:0] tm_a2_r;
  logic [TRAM_W-1:0]    tram_rd;
  logic [TRAM_W-1:0]    tram_rd2;

  // Valid flags clear asynchronously so a reset takes effect mid-cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid   <= '0;
      tm_a_r  <= '0;
      tm_a2_r <= '0;
    end else begin
      tm_a_r  <= tm_a;
      tm_a2_r <= tm_a2;
      if (tm_we) begin
        valid[tm_a] <= tm_di[tag_width-1];
      end
    end
  end

  fmlbrg_dpram #(
    .ADDR_W (tag_depth),
    .LANES  (1),
    .LANE_W (TRAM_W)
  ) u_tag_ram (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .a      (tm_a),
    .we     (tm_we),
    .di     (tm_di[tag_width-2:0]),
    .rdata  (tram_rd),
    .a2     (tm_a2),
    .rdata2 (tram_rd2)
  );

  assign tm_do  = {valid[tm_a_r],  tram_rd};
  assign tm_do2 = {valid[tm_a2_r], tram_rd2};

  fmlbrg_dpram #(
    .ADDR_W (data_depth),
    .LANES  (BYTE_LANES),
    .LANE_W (BYTE_W)
  ) u_data_ram (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .a      (dm_a),
    .we     (dm_we),
    .di     (dm_di),
    .rdata  (dm_do),
    .a2     (dm_a2),
    .rdata2 (dm_do2)
  );

endmodule

// File: tb/tb_fmlbrg_cachemem.sv
// Self-checking bench for fmlbrg_cachemem: directed scenarios plus random
// traffic compared against an array-based model of the cache storage.
module tb_fmlbrg_cachemem;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [4:0]  tm_a, tm_a2;
  logic        tm_we;
  logic [15:0] tm_di, tm_do, tm_do2;
  logic [7:0]  dm_a, dm_a2;
  logic [1:0]  dm_we;
  logic [15:0] dm_di, dm_do, dm_do2;

  int checks = 0;
  int errors = 0;

  // Reference model: contents, valid flags, and which bits have ever been written.
  logic [14:0] tag_m  [32];
  logic        val_m  [32];
  logic        tag_k  [32];
  logic [15:0] dat_m  [256];
  logic [1:0]  dat_k  [256];
  logic [4:0]  ra_tm, ra_tm2;
  logic [7:0]  ra_dm, ra_dm2;

  always #5 sys_clk = ~sys_clk;

  fmlbrg_cachemem dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tm_a      (tm_a),
    .tm_we     (tm_we),
    .tm_di     (tm_di),
    .tm_do     (tm_do),
    .tm_a2     (tm_a2),
    .tm_do2    (tm_do2),
    .dm_a      (dm_a),
    .dm_we     (dm_we),
    .dm_di     (dm_di),
    .dm_do     (dm_do),
    .dm_a2     (dm_a2),
    .dm_do2    (dm_do2)
  );

  function automatic logic [15:0] tag_exp(input logic [4:0] a);
    return {val_m[a], tag_m[a]};
  endfunction

  function automatic logic [15:0] tag_mask(input logic [4:0] a);
    return tag_k[a] ? 16'hFFFF : 16'h8000;
  endfunction

  function automatic logic [15:0] dat_mask(input logic [7:0] a);
    return {{8{dat_k[a][1]}}, {8{dat_k[a][0]}}};
  endfunction

  // One clock: the model absorbs the edge's writes, then we move to the falling edge.
  task automatic step();
    @(posedge sys_clk);
    if (!sys_rst_n) begin
      for (int i = 0; i < 32; i++) val_m[i] = 1'b0;
      ra_tm = '0; ra_tm2 = '0; ra_dm = '0; ra_dm2 = '0;
    end else begin
      if (tm_we) begin
        tag_m[tm_a] = tm_di[14:0];
        val_m[tm_a] = tm_di[15];
        tag_k[tm_a] = 1'b1;
      end
      for (int b = 0; b < 2; b++) begin
        if (dm_we[b]) begin
          dat_m[dm_a][b*8 +: 8] = dm_di[b*8 +: 8];
          dat_k[dm_a][b] = 1'b1;
        end
      end
      ra_tm = tm_a; ra_tm2 = tm_a2; ra_dm = dm_a; ra_dm2 = dm_a2;
    end
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tm_a = '0; tm_a2 = '0; tm_we = 1'b0; tm_di = '0;
    dm_a = '0; dm_a2 = '0; dm_we = '0; dm_di = '0;
    for (int i = 0; i < 32; i++) begin
      tag_k[i] = 1'b0; val_m[i] = 1'b0; tag_m[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      dat_k[i] = 2'b00; dat_m[i] = '0;
    end
    step(); step();
    checks++;
    if (tm_do[15] !== 1'b0 || tm_do2[15] !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_in_reset tm_do=%h tm_do2=%h required bit15=0", tm_do, tm_do2);
    end
    sys_rst_n = 1'b1;
    tm_a = 5'd3; tm_a2 = 5'd7;
    step();
    checks++;
    if (tm_do[15] !== 1'b0 || tm_do2[15] !== 1'b0) begin
      errors++;
      $display("FAIL reset_read_3_7 tm_do=%h tm_do2=%h required bit15=0", tm_do, tm_do2);
    end
    for (int i = 0; i < 32; i++) begin
      tm_a = 5'(i); tm_a2 = 5'(31 - i);
      step();
      checks++;
      if (tm_do[15] !== 1'b0 || tm_do2[15] !== 1'b0) begin
        errors++;
        $display("FAIL reset_sweep idx=%0d tm_do=%h tm_do2=%h required bit15=0", i, tm_do, tm_do2);
      end
    end
  endtask

  task automatic test_tag_latency();
    tm_a = 5'd5; tm_we = 1'b1; tm_di = 16'hC123;
    step();
    tm_we = 1'b0; tm_a = 5'd5; tm_a2 = 5'd5;
    step();
    checks++;
    if (tm_do !== 16'hC123) begin
      errors++;
      $display("FAIL tag_port1_read got=%h required=%h", tm_do, 16'hC123);
    end
    checks++;
    if (tm_do2 !== 16'hC123) begin
      errors++;
      $display("FAIL tag_port2_read got=%h required=%h", tm_do2, 16'hC123);
    end
  endtask

  task automatic test_byte_enables();
    dm_a = 8'h10; dm_di = 16'hAAAA; dm_we = 2'b11;
    step();
    checks++;
    if (dm_do !== 16'hAAAA) begin
      errors++;
      $display("FAIL byte_en_full got=%h required=%h", dm_do, 16'hAAAA);
    end
    dm_di = 16'h5566; dm_we = 2'b01;
    step();
    checks++;
    if (dm_do !== 16'hAA66) begin
      errors++;
      $display("FAIL byte_en_low got=%h required=%h", dm_do, 16'hAA66);
    end
    dm_di = 16'h77FF; dm_we = 2'b10;
    step();
    checks++;
    if (dm_do !== 16'h7766) begin
      errors++;
      $display("FAIL byte_en_high got=%h required=%h", dm_do, 16'h7766);
    end
    dm_di = 16'h0000; dm_we = 2'b00;
    step();
    checks++;
    if (dm_do !== 16'h7766) begin
      errors++;
      $display("FAIL byte_en_none got=%h required=%h", dm_do, 16'h7766);
    end
  endtask

  task automatic test_write_first();
    dm_a = 8'h20; dm_we = 2'b11; dm_di = 16'h1234; dm_a2 = 8'h20;
    step();
    dm_we = 2'b00;
    checks++;
    if (dm_do !== 16'h1234 || dm_do2 !== 16'h1234) begin
      errors++;
      $display("FAIL write_first dm_do=%h dm_do2=%h required=%h", dm_do, dm_do2, 16'h1234);
    end
  endtask

  task automatic test_dual_port();
    logic [15:0] w;
    for (int i = 0; i < 8; i++) begin
      dm_a = 8'(8'h40 + i); dm_we = 2'b11; dm_di = 16'(16'h0100 + i);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      dm_a = 8'h80; dm_we = 2'b11; dm_di = w; dm_a2 = 8'(8'h40 + i);
      step();
      checks++;
      if (dm_do2 !== 16'(16'h0100 + i) || dm_do !== w) begin
        errors++;
        $display("FAIL dual_port i=%0d dm_do2=%h required=%h dm_do=%h required=%h",
                 i, dm_do2, 16'(16'h0100 + i), dm_do, w);
      end
    end
    dm_we = 2'b00;
  endtask

  task automatic test_random();
    logic [15:0] m;
    for (int n = 0; n < 400; n++) begin
      tm_a  = 5'($urandom);
      tm_a2 = ($urandom_range(0, 3) == 0) ? tm_a : 5'($urandom);
      tm_we = ($urandom_range(0, 2) == 0);
      tm_di = 16'($urandom);
      dm_a  = 8'($urandom_range(0, 31));
      dm_a2 = ($urandom_range(0, 3) == 0) ? dm_a : 8'($urandom_range(0, 31));
      dm_we = 2'($urandom);
      dm_di = 16'($urandom);
      step();
      m = tag_mask(ra_tm);
      checks++;
      if ((tm_do & m) !== (tag_exp(ra_tm) & m)) begin
        errors++;
        $display("FAIL rand_tm_do n=%0d a=%0d got=%h required=%h mask=%h", n, ra_tm, tm_do, tag_exp(ra_tm), m);
      end
      m = tag_mask(ra_tm2);
      checks++;
      if ((tm_do2 & m) !== (tag_exp(ra_tm2) & m)) begin
        errors++;
        $display("FAIL rand_tm_do2 n=%0d a=%0d got=%h required=%h mask=%h", n, ra_tm2, tm_do2, tag_exp(ra_tm2), m);
      end
      m = dat_mask(ra_dm);
      checks++;
      if ((dm_do & m) !== (dat_m[ra_dm] & m)) begin
        errors++;
        $display("FAIL rand_dm_do n=%0d a=%h got=%h required=%h mask=%h", n, ra_dm, dm_do, dat_m[ra_dm], m);
      end
      m = dat_mask(ra_dm2);
      checks++;
      if ((dm_do2 & m) !== (dat_m[ra_dm2] & m)) begin
        errors++;
        $display("FAIL rand_dm_do2 n=%0d a=%h got=%h required=%h mask=%h", n, ra_dm2, dm_do2, dat_m[ra_dm2], m);
      end
    end
    tm_we = 1'b0; dm_we = 2'b00;
  endtask

  task automatic test_mid_reset();
    tm_a = 5'd9; tm_we = 1'b1; tm_di = 16'h8001;
    step();
    tm_we = 1'b0; tm_a2 = 5'd9;
    step();
    checks++;
    if (tm_do !== 16'h8001 || tm_do2 !== 16'h8001) begin
      errors++;
      $display("FAIL mid_reset_setup tm_do=%h tm_do2=%h required=%h", tm_do, tm_do2, 16'h8001);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (tm_do[15] !== 1'b0 || tm_do2[15] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async tm_do=%h tm_do2=%h required bit15=0", tm_do, tm_do2);
    end
    tm_a = 5'd9; tm_we = 1'b1; tm_di = 16'h8555;
    dm_a = 8'h10; dm_we = 2'b11; dm_di = 16'hDEAD;
    step();
    sys_rst_n = 1'b1;
    tm_we = 1'b0; dm_we = 2'b00; tm_a = 5'd9; tm_a2 = 5'd9; dm_a = 8'h10;
    step();
    checks++;
    if (tm_do !== 16'h0001 || tm_do2 !== 16'h0001) begin
      errors++;
      $display("FAIL mid_reset_tag_kept tm_do=%h tm_do2=%h required=%h", tm_do, tm_do2, 16'h0001);
    end
    checks++;
    if (dm_do !== 16'h7766) begin
      errors++;
      $display("FAIL mid_reset_data_write_ignored dm_do=%h required=%h", dm_do, 16'h7766);
    end
  endtask

  initial begin
    test_reset();
    test_tag_latency();
    test_byte_enables();
    test_write_first();
    test_dual_port();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
